// File: rtl/game_pkg.sv
// Shared types and helpers for the guessing game: FSM state encoding,
// BCD digit limits and the max_digits masking rule.
package game_pkg;

   localparam int DIGIT_MAX  = 9;
   localparam int NUM_DIGITS = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_PLAY = 3'd2,
      ST_EVAL = 3'd3,
      ST_WIN  = 3'd4,
      ST_LOSE = 3'd5
   } game_state_t;

   // idx 0 is the ones digit; a max_digits of 0 behaves like 1.
   function automatic logic digit_keep(input logic [1:0] max_digits,
                                       input logic [1:0] idx);
      logic [1:0] active;
      active = (max_digits == 2'd0) ? 2'd1 : max_digits;
      return idx < active;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One mod-10 BCD digit with enable in and carry out; chain carry into the
// next digit's enable to build a multi-digit decimal counter.
module bcd_digit_counter
   import game_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;
   logic               at_max;

   assign at_max = (digit_q == DIGIT_W'(DIGIT_MAX));

   always_comb begin
      digit_d = digit_q;
      if (en) begin
         digit_d = at_max ? '0 : digit_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = en && at_max;

endmodule

// File: rtl/guess_evaluator.sv
// Game control: captures a secret from a free-running BCD counter, evaluates
// confirmed guesses digit-wise and drives hints and the win/lose result.
module guess_evaluator
   import game_pkg::*;
#(
   parameter int DIGIT_W = 4,
   parameter int GUESS_W = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               confirm,
   input  logic [DIGIT_W-1:0] guess_digit_1,
   input  logic [DIGIT_W-1:0] guess_digit_2,
   input  logic [DIGIT_W-1:0] guess_digit_3,
   input  logic [1:0]         max_digits,
   input  logic [GUESS_W-1:0] max_guesses,
   output logic               hint_higher,
   output logic               hint_lower,
   output logic               win,
   output logic               lose,
   output logic [GUESS_W-1:0] guesses_used,
   output logic [2:0]         game_state
);

   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

   game_state_t        state_q, state_d;
   logic               confirm_q;
   digits_t            secret_q, secret_d;
   digits_t            guess_q, guess_d;
   logic [GUESS_W-1:0] used_q, used_d;
   logic               hh_q, hh_d;
   logic               hl_q, hl_d;
   logic               win_q, win_d;
   logic               lose_q, lose_d;

   digits_t            cnt_digits;
   digits_t            cnt_masked;
   digits_t            guess_in;
   digits_t            guess_masked;
   logic               cnt_c0, cnt_c1, cnt_unused_carry;
   logic               guess_eq, guess_lt;

   // Secret source: never gated, so the captured value depends only on timing.
   bcd_digit_counter #(.DIGIT_W(DIGIT_W)) u_cnt_ones (
      .clk(clk), .reset_n(reset_n), .en(1'b1),
      .digit(cnt_digits[0]), .carry(cnt_c0)
   );
   bcd_digit_counter #(.DIGIT_W(DIGIT_W)) u_cnt_tens (
      .clk(clk), .reset_n(reset_n), .en(cnt_c0),
      .digit(cnt_digits[1]), .carry(cnt_c1)
   );
   bcd_digit_counter #(.DIGIT_W(DIGIT_W)) u_cnt_hundreds (
      .clk(clk), .reset_n(reset_n), .en(cnt_c1),
      .digit(cnt_digits[2]), .carry(cnt_unused_carry)
   );

   assign guess_in = {guess_digit_3, guess_digit_2, guess_digit_1};

   always_comb begin
      cnt_masked   = '0;
      guess_masked = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_keep(max_digits, 2'(i))) begin
            cnt_masked[i]   = cnt_digits[i];
            guess_masked[i] = guess_in[i];
         end
      end
   end

   // Most significant differing digit decides; raw 4-bit values compare as-is.
   always_comb begin
      guess_eq = 1'b1;
      guess_lt = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (guess_eq && (guess_q[i] != secret_q[i])) begin
            guess_eq = 1'b0;
            guess_lt = (guess_q[i] < secret_q[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_ARM;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ARM:  state_d = (max_guesses == '0) ? ST_LOSE : ST_PLAY;
            ST_PLAY: if (confirm_q) state_d = ST_EVAL;
            ST_EVAL: begin
               if (guess_eq)                     state_d = ST_WIN;
               else if (used_q >= max_guesses)   state_d = ST_LOSE;
               else                              state_d = ST_PLAY;
            end
            ST_WIN:  state_d = ST_WIN;
            ST_LOSE: state_d = ST_LOSE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      secret_d = secret_q;
      guess_d  = guess_q;
      used_d   = used_q;
      hh_d     = hh_q;
      hl_d     = hl_q;
      win_d    = win_q;
      lose_d   = lose_q;
      if (!start) begin
         case (state_q)
            ST_ARM: begin
               secret_d = cnt_masked;
               used_d   = '0;
               hh_d     = 1'b0;
               hl_d     = 1'b0;
               win_d    = 1'b0;
               lose_d   = (max_guesses == '0);
            end
            ST_PLAY: begin
               if (confirm_q) begin
                  guess_d = guess_masked;
                  if (used_q < max_guesses) used_d = used_q + 1'b1;
               end
            end
            ST_EVAL: begin
               if (guess_eq) begin
                  win_d = 1'b1;
                  hh_d  = 1'b0;
                  hl_d  = 1'b0;
               end else begin
                  hh_d = guess_lt;
                  hl_d = !guess_lt;
                  if (used_q >= max_guesses) lose_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         confirm_q <= 1'b0;
         secret_q  <= '0;
         guess_q   <= '0;
         used_q    <= '0;
         hh_q      <= 1'b0;
         hl_q      <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
      end else begin
         confirm_q <= confirm;
         secret_q  <= secret_d;
         guess_q   <= guess_d;
         used_q    <= used_d;
         hh_q      <= hh_d;
         hl_q      <= hl_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
      end
   end

   assign hint_higher  = hh_q;
   assign hint_lower   = hl_q;
   assign win          = win_q;
   assign lose         = lose_q;
   assign guesses_used = used_q;
   assign game_state   = state_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Bench for guess_evaluator: directed game scenarios plus randomized games
// checked against a decimal-arithmetic model of the game rules.
`timescale 1ns/1ps
module tb_guess_evaluator;
   import game_pkg::*;

   localparam int DIGIT_W = 4;
   localparam int GUESS_W = 3;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic               confirm = 1'b0;
   logic [DIGIT_W-1:0] guess_digit_1 = '0;
   logic [DIGIT_W-1:0] guess_digit_2 = '0;
   logic [DIGIT_W-1:0] guess_digit_3 = '0;
   logic [1:0]         max_digits = 2'd3;
   logic [GUESS_W-1:0] max_guesses = '0;
   logic               hint_higher, hint_lower, win, lose;
   logic [GUESS_W-1:0] guesses_used;
   logic [2:0]         game_state;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: counter as a decimal number, game as plain integers.
   int          model_cnt = 0;
   int          m_secret, m_max, m_used, m_keep;
   int          m_hh, m_hl, m_win, m_lose;
   game_state_t m_state;

   guess_evaluator #(.DIGIT_W(DIGIT_W), .GUESS_W(GUESS_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .confirm(confirm),
      .guess_digit_1(guess_digit_1), .guess_digit_2(guess_digit_2),
      .guess_digit_3(guess_digit_3), .max_digits(max_digits),
      .max_guesses(max_guesses), .hint_higher(hint_higher),
      .hint_lower(hint_lower), .win(win), .lose(lose),
      .guesses_used(guesses_used), .game_state(game_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset_n) model_cnt = 0;
      else          model_cnt = (model_cnt + 1) % 1000;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_state"}, 32'(game_state), 32'(m_state));
      check({tag, "_hh"}, 32'(hint_higher), m_hh);
      check({tag, "_hl"}, 32'(hint_lower), m_hl);
      check({tag, "_win"}, 32'(win), m_win);
      check({tag, "_lose"}, 32'(lose), m_lose);
      check({tag, "_used"}, 32'(guesses_used), m_used);
   endtask

   task automatic model_clear();
      m_state = ST_IDLE;
      m_hh = 0; m_hl = 0; m_win = 0; m_lose = 0; m_used = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0;
      confirm = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      check_outputs("reset");
   endtask

   task automatic wait_cnt(input int target);
      int n = 0;
      while (model_cnt != target && n < 1100) begin
         @(negedge clk);
         n++;
      end
      check("cnt_sync_timeout", 32'(n < 1100), 32'd1);
   endtask

   // Starts a game at the current negedge; optionally with a colliding confirm.
   task automatic start_game(input int md, input int mg, input bit with_confirm);
      max_digits  = 2'(md);
      max_guesses = GUESS_W'(mg);
      start       = 1'b1;
      confirm     = with_confirm;
      m_keep   = (md == 0) ? 1 : md;
      m_secret = ((model_cnt + 1) % 1000) % ((m_keep == 1) ? 10 : (m_keep == 2) ? 100 : 1000);
      m_max    = mg;
      @(negedge clk);
      start   = 1'b0;
      confirm = 1'b0;
      check("arm_state", 32'(game_state), 32'(ST_ARM));
      @(negedge clk);
      m_used = 0; m_hh = 0; m_hl = 0; m_win = 0;
      m_lose  = (mg == 0) ? 1 : 0;
      m_state = (mg == 0) ? ST_LOSE : ST_PLAY;
      check_outputs("after_arm");
   endtask

   task automatic model_eval(input int d3, input int d2, input int d1);
      int g, s;
      if (m_state != ST_PLAY) return;
      g = d1 + ((m_keep >= 2) ? d2 * 16 : 0) + ((m_keep >= 3) ? d3 * 256 : 0);
      s = (m_secret % 10) + ((m_secret / 10) % 10) * 16 + (m_secret / 100) * 256;
      if (m_used < m_max) m_used++;
      if (g == s) begin
         m_win = 1; m_hh = 0; m_hl = 0; m_state = ST_WIN;
      end else begin
         m_hh = (g < s) ? 1 : 0;
         m_hl = (g > s) ? 1 : 0;
         if (m_used >= m_max) begin
            m_lose = 1; m_state = ST_LOSE;
         end else begin
            m_state = ST_PLAY;
         end
      end
   endtask

   task automatic do_guess(input string tag, input int d3, input int d2, input int d1);
      guess_digit_3 = DIGIT_W'(d3);
      guess_digit_2 = DIGIT_W'(d2);
      guess_digit_1 = DIGIT_W'(d1);
      confirm = 1'b1;
      @(negedge clk);
      confirm = 1'b0;
      repeat (2) @(negedge clk);
      model_eval(d3, d2, d1);
      check_outputs(tag);
   endtask

   function automatic int rnd_digit();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
   endfunction

   initial begin
      do_reset();

      // Secret 347, two wrong guesses then a win, then an ignored confirm.
      wait_cnt(346);
      start_game(3, 4, 1'b0);
      do_guess("g200", 2, 0, 0);
      do_guess("g500", 5, 0, 0);
      do_guess("g347", 3, 4, 7);
      do_guess("after_win", 1, 1, 1);

      // Running out of guesses.
      wait_cnt(346);
      start_game(3, 2, 1'b0);
      do_guess("g100", 1, 0, 0);
      do_guess("g900_lose", 9, 0, 0);
      do_guess("after_lose", 3, 4, 7);

      // One active digit: secret 007, upper guess digits ignored.
      wait_cnt(346);
      start_game(1, 3, 1'b0);
      do_guess("g557_masked", 5, 5, 7);

      // start and confirm together: confirm is dropped.
      start_game(3, 3, 1'b1);
      repeat (2) @(negedge clk);
      check_outputs("start_confirm_hold");

      // Reset asserted while evaluating.
      start_game(2, 3, 1'b0);
      guess_digit_1 = 4'd1;
      confirm = 1'b1;
      @(negedge clk);
      confirm = 1'b0;
      @(negedge clk);
      check("in_eval", 32'(game_state), 32'(ST_EVAL));
      reset_n = 1'b0;
      #1;
      model_clear();
      check_outputs("reset_in_eval");
      @(negedge clk);
      reset_n = 1'b1;

      // No guesses allowed.
      start_game(3, 0, 1'b0);
      do_guess("zero_max", 0, 0, 0);

      // Randomized games, including aborts of unfinished games.
      for (int gnum = 0; gnum < 30; gnum++) begin
         int md, mg, ng;
         repeat ($urandom_range(0, 20)) @(negedge clk);
         md = $urandom_range(0, 3);
         mg = $urandom_range(0, 5);
         start_game(md, mg, ($urandom_range(0, 5) == 0));
         ng = $urandom_range(1, mg + 2);
         for (int k = 0; k < ng; k++) begin
            int d3, d2, d1;
            if ($urandom_range(0, 3) == 0) begin
               d1 = m_secret % 10;
               d2 = (m_keep >= 2) ? (m_secret / 10) % 10 : rnd_digit();
               d3 = (m_keep >= 3) ? m_secret / 100 : rnd_digit();
            end else begin
               d1 = rnd_digit();
               d2 = rnd_digit();
               d3 = rnd_digit();
            end
            do_guess("rand", d3, d2, d1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
